bcd_display_scan: RTL and testbench
===================================

# bcd_display_scan

Two-digit multiplexed 7-segment scan driver that sits directly downstream of the BCD counter: it consumes the tens/units BCD digits and drives a common-anode-select, shared-segment LED display. It time-multiplexes the two digits with a programmable refresh prescaler and inserts anode dead-time at each digit switch to prevent ghosting. It also provides frame-synchronous digit capture to avoid tearing, leading-zero blanking, blinking, and an invalid-BCD indication.

## Interface
- SCAN_DIV, 1000: clock cycles per digit slot; must be >= 2.
- DEAD_CYCLES, 16: cycles at the start of each slot with both anodes off; must be < SCAN_DIV.
- BLINK_FRAMES, 64: frames per blink half-period; must be >= 1.
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- digit1  in  4  tens digit, BCD.
- digit0  in  4  units digit, BCD.
- blank_lz  in  1  1 = suppress tens digit when captured tens == 0.
- blink_en  in  1  1 = blink whole display.
- seg  out  7  segment drive, active-high; seg[0]=a … seg[6]=g.
- an  out  2  digit enables, active-high, one-hot or zero; an[0]=units, an[1]=tens.
- frame_tick  out  1  one-cycle pulse at each frame start.

## Operation
- State: slot counter cnt (0..SCAN_DIV-1, width $clog2(SCAN_DIV)); slot bit s (0=units, 1=tens); shadow digits sh1/sh0; frame counter fcnt (0..BLINK_FRAMES-1); blink phase bp.
- cnt increments every cycle; at cnt==SCAN_DIV-1 it wraps to 0 and s toggles. A frame = slot 0 followed by slot 1 (2*SCAN_DIV cycles).
- Frame boundary = cycle with s==1 and cnt==SCAN_DIV-1. On its edge: sh1<=digit1, sh0<=digit0; fcnt increments. If fcnt==BLINK_FRAMES-1, fcnt wraps to 0 and bp toggles. Inputs are sampled only at this edge; changes mid-frame are not displayed until the next frame.
- Decode of selected shadow digit (sh0 in slot 0, sh1 in slot 1): 0=3F,1=06,2=5B,3=4F,4=66,5=6D,6=7D,7=07,8=7F,9=6F (hex, bit0=a). Values 10..15 show dash 40.
- Anode enable for slot s is high iff cnt >= DEAD_CYCLES, AND NOT (blink_en AND bp==1), AND NOT (s==1 AND blank_lz AND sh1==0). Otherwise an=00.
- Invalid tens digit is never blanked by blank_lz; only sh1==0 is blanked.
- seg is driven with the decoded pattern whenever the corresponding anode is on. It is 00 whenever an==00.
- fcnt and bp run regardless of blink_en. Deasserting blink_en restores the display on the next cycle's output.

## Timing
- Reset value: cnt=0, s=0, sh1=sh0=0, fcnt=0, bp=0, seg=00, an=00, frame_tick=0. Reset has priority over all other activity and takes effect at the next edge, including mid-slot and mid-frame.
- seg, an and frame_tick are registered. Their value in cycle t+1 is a function of state and inputs (blank_lz, blink_en) in cycle t.
- frame_tick is high in the cycle in which state is s=0, cnt=0, following a frame boundary. It does not pulse in the first cycle after reset.
- First cycle after reset release: the state is s=0, cnt=0. The units anode first turns on at output cycle DEAD_CYCLES+1 after reset release.
- Dead-time: within each slot, an is 00 for exactly DEAD_CYCLES output cycles, then the slot's anode is on for SCAN_DIV-DEAD_CYCLES output cycles. The two anodes are never simultaneously high.
- Latency from input change to display: captured at the next frame boundary. The new units value is visible DEAD_CYCLES+1 cycles after that boundary edge.
- Blink period: 2*BLINK_FRAMES frames. The display is on for the first BLINK_FRAMES frames after reset, then off for the next BLINK_FRAMES frames.

## Test plan
All scenarios use SCAN_DIV=8, DEAD_CYCLES=2, BLINK_FRAMES=2.
- Reset, digits=4/7, blank_lz=0, blink_en=0 -> first frame shows 0/0: an=01, seg=3F for 6 cycles, then an=00 for 2 cycles, then an=10, seg=3F for 6 cycles. From frame 2: an=01/seg=07 and an=10/seg=66; frame_tick pulses once per 16 cycles.
- Change digit0 from 7 to 2 mid-slot-0 -> seg stays 07 for the rest of that frame. 5B appears in units slot of next frame; no torn frame.
- Digits 0/5, blank_lz=1 -> an[1] never asserts, units shows 6D. Repeat with digits 0xA/5 -> tens shows 40 (not blanked).
- blink_en=1 -> display on for frames 0–1 after reset, an=00 for frames 2–3, repeating. Drop blink_en during an off frame -> an resumes next cycle per slot schedule.
- Assert rst for one cycle mid-slot 1 -> next output cycle an=00, seg=00, frame_tick=0; the counter restarts at slot 0, cnt 0, and the shadow reads 0/0.
- Every cycle, all scenarios -> assert an != 11, and seg==00 whenever an==00.

Source files
------------

// File: rtl/bcd_display_scan.sv
// Two-digit multiplexed 7-segment scan driver with anode dead-time, frame-synchronous
// digit capture, leading-zero blanking, blinking and dash display for invalid BCD.
module bcd_display_scan #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEAD_CYCLES  = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit1,
    input  logic [3:0] digit0,
    input  logic       blank_lz,
    input  logic       blink_en,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame_tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEAD_END = CW'(DEAD_CYCLES);
    localparam logic [FW-1:0] FCNT_MAX = FW'(BLINK_FRAMES - 1);

    logic [CW-1:0] cnt;
    logic          s;
    logic [3:0]    sh1;
    logic [3:0]    sh0;
    logic [FW-1:0] fcnt;
    logic          bp;

    logic [3:0]    cur_digit;
    logic [6:0]    dec;
    logic          lit;
    logic          frame_end;
    logic [1:0]    an_nxt;
    logic [6:0]    seg_nxt;

    always_comb begin
        cur_digit = s ? sh1 : sh0;
        dec       = 7'h40;
        case (cur_digit)
            4'd0:    dec = 7'h3F;
            4'd1:    dec = 7'h06;
            4'd2:    dec = 7'h5B;
            4'd3:    dec = 7'h4F;
            4'd4:    dec = 7'h66;
            4'd5:    dec = 7'h6D;
            4'd6:    dec = 7'h7D;
            4'd7:    dec = 7'h07;
            4'd8:    dec = 7'h7F;
            4'd9:    dec = 7'h6F;
            default: dec = 7'h40;
        endcase

        // Only a captured tens value of exactly zero is blanked; invalid codes still show a dash.
        lit       = (cnt >= DEAD_END) && !(blink_en && bp) && !(s && blank_lz && (sh1 == 4'd0));
        frame_end = s && (cnt == CNT_MAX);
        an_nxt    = lit ? (s ? 2'b10 : 2'b01) : 2'b00;
        seg_nxt   = lit ? dec : 7'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            s          <= 1'b0;
            sh1        <= 4'd0;
            sh0        <= 4'd0;
            fcnt       <= '0;
            bp         <= 1'b0;
            seg        <= 7'h00;
            an         <= 2'b00;
            frame_tick <= 1'b0;
        end else begin
            seg        <= seg_nxt;
            an         <= an_nxt;
            frame_tick <= frame_end;

            if (cnt == CNT_MAX) begin
                cnt <= '0;
                s   <= ~s;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // Digits are captured only here so a frame never mixes old and new values.
            if (frame_end) begin
                sh1 <= digit1;
                sh0 <= digit0;
                if (fcnt == FCNT_MAX) begin
                    fcnt <= '0;
                    bp   <= ~bp;
                end else begin
                    fcnt <= fcnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Directed bench for bcd_display_scan with a small display configuration
// (8 cycles per slot, 2 dead cycles, 2 frames per blink half-period).
module tb_bcd_display_scan;

    localparam int SD = 8;
    localparam int DC = 2;
    localparam int BF = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] digit1 = 4'd4;
    logic [3:0] digit0 = 4'd7;
    logic       blank_lz = 1'b0;
    logic       blink_en = 1'b0;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bcd_display_scan #(
        .SCAN_DIV(SD),
        .DEAD_CYCLES(DC),
        .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk),
        .rst(rst),
        .digit1(digit1),
        .digit0(digit0),
        .blank_lz(blank_lz),
        .blink_en(blink_en),
        .seg(seg),
        .an(an),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Invariants hold in every cycle of every scenario.
    always @(negedge clk) begin
        checks++;
        if (an === 2'b11) begin
            errors++;
            $display("[TB] FAIL onehot an=%b required not 11", an);
        end
        if (an === 2'b00) begin
            checks++;
            if (seg !== 7'h00) begin
                errors++;
                $display("[TB] FAIL dark_seg seg=%h required 00 while an=00", seg);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic test_reset();
        digit1 = 4'd4; digit0 = 4'd7; blank_lz = 1'b0; blink_en = 1'b0;
        rst = 1'b1;
        step();
        step();
        checks++;
        if (an !== 2'b00 || seg !== 7'h00 || frame_tick !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_hold an=%b seg=%h ft=%b required 00/00/0", an, seg, frame_tick);
        end
        rst = 1'b0;
        cyc = 0;
        checks++;
        if (an !== 2'b00 || seg !== 7'h00 || frame_tick !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_cycle0 an=%b seg=%h ft=%b required 00/00/0", an, seg, frame_tick);
        end
        step();
        step();
        checks++;
        if (an !== 2'b00 || frame_tick !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_dead an=%b ft=%b required 00/0", an, frame_tick);
        end
        step();
        checks++;
        if (an !== 2'b01 || seg !== 7'h3F) begin
            errors++;
            $display("[TB] FAIL reset_first_on an=%b seg=%h required 01/3f", an, seg);
        end
    endtask

    task automatic test_scan();
        digit1 = 4'd4; digit0 = 4'd7; blank_lz = 1'b0; blink_en = 1'b0;
        do_reset();
        repeat (32) begin
            int q, fr;
            logic [1:0] ea;
            logic [6:0] es;
            logic eft;
            step();
            q   = (cyc - 1) % 16;
            fr  = (cyc - 1) / 16;
            ea  = ((q % 8) >= DC) ? ((q >= 8) ? 2'b10 : 2'b01) : 2'b00;
            es  = (ea == 2'b00) ? 7'h00 : (fr == 0) ? 7'h3F : (ea == 2'b01) ? 7'h07 : 7'h66;
            eft = (cyc % 16) == 0;
            checks++;
            if (an !== ea) begin
                errors++;
                $display("[TB] FAIL scan_an cyc=%0d an=%b required %b", cyc, an, ea);
            end
            checks++;
            if (seg !== es) begin
                errors++;
                $display("[TB] FAIL scan_seg cyc=%0d seg=%h required %h", cyc, seg, es);
            end
            checks++;
            if (frame_tick !== eft) begin
                errors++;
                $display("[TB] FAIL scan_tick cyc=%0d ft=%b required %b", cyc, frame_tick, eft);
            end
        end
    endtask

    task automatic test_tearing();
        digit1 = 4'd4; digit0 = 4'd7; blank_lz = 1'b0; blink_en = 1'b0;
        do_reset();
        while (cyc < 20) step();
        digit0 = 4'd2;
        while (cyc < 40) begin
            int q, fr;
            logic [1:0] ea;
            logic [6:0] es;
            step();
            q  = (cyc - 1) % 16;
            fr = (cyc - 1) / 16;
            ea = ((q % 8) >= DC) ? ((q >= 8) ? 2'b10 : 2'b01) : 2'b00;
            es = (ea == 2'b00) ? 7'h00 : (ea == 2'b10) ? 7'h66 : (fr == 1) ? 7'h07 : 7'h5B;
            checks++;
            if (an !== ea || seg !== es) begin
                errors++;
                $display("[TB] FAIL tearing cyc=%0d an=%b seg=%h required %b/%h", cyc, an, seg, ea, es);
            end
        end
    endtask

    task automatic test_blank();
        for (int pass = 0; pass < 2; pass++) begin
            digit1 = (pass == 0) ? 4'd0 : 4'hA;
            digit0 = 4'd5;
            blank_lz = 1'b1; blink_en = 1'b0;
            do_reset();
            repeat (48) begin
                int q, fr;
                logic [1:0] ea;
                logic [6:0] es;
                step();
                q  = (cyc - 1) % 16;
                fr = (cyc - 1) / 16;
                if ((q % 8) < DC)
                    ea = 2'b00;
                else if (q < 8)
                    ea = 2'b01;
                else if (pass == 1 && fr >= 1)
                    ea = 2'b10;
                else
                    ea = 2'b00;
                es = (ea == 2'b00) ? 7'h00 : (ea == 2'b10) ? 7'h40 : (fr == 0) ? 7'h3F : 7'h6D;
                checks++;
                if (an !== ea || seg !== es) begin
                    errors++;
                    $display("[TB] FAIL blank pass=%0d cyc=%0d an=%b seg=%h required %b/%h",
                             pass, cyc, an, seg, ea, es);
                end
            end
        end
        blank_lz = 1'b0;
    endtask

    task automatic test_blink();
        digit1 = 4'd4; digit0 = 4'd7; blank_lz = 1'b0; blink_en = 1'b1;
        do_reset();
        repeat (80) begin
            int q, fr;
            logic [1:0] ea;
            logic [6:0] es;
            step();
            q  = (cyc - 1) % 16;
            fr = (cyc - 1) / 16;
            ea = ((q % 8) >= DC && (fr % 4) < 2) ? ((q >= 8) ? 2'b10 : 2'b01) : 2'b00;
            es = (ea == 2'b00) ? 7'h00 : (fr == 0) ? 7'h3F : (ea == 2'b01) ? 7'h07 : 7'h66;
            checks++;
            if (an !== ea || seg !== es) begin
                errors++;
                $display("[TB] FAIL blink cyc=%0d an=%b seg=%h required %b/%h", cyc, an, seg, ea, es);
            end
        end

        do_reset();
        while (cyc < 37) step();
        checks++;
        if (an !== 2'b00) begin
            errors++;
            $display("[TB] FAIL blink_off cyc=%0d an=%b required 00", cyc, an);
        end
        blink_en = 1'b0;
        repeat (3) begin
            step();
            checks++;
            if (an !== 2'b01 || seg !== 7'h07) begin
                errors++;
                $display("[TB] FAIL blink_drop cyc=%0d an=%b seg=%h required 01/07", cyc, an, seg);
            end
        end
    endtask

    task automatic test_mid_reset();
        digit1 = 4'd4; digit0 = 4'd7; blank_lz = 1'b0; blink_en = 1'b0;
        do_reset();
        while (cyc < 27) step();
        checks++;
        if (an !== 2'b10 || seg !== 7'h66) begin
            errors++;
            $display("[TB] FAIL midrst_before an=%b seg=%h required 10/66", an, seg);
        end
        rst = 1'b1;
        step();
        checks++;
        if (an !== 2'b00 || seg !== 7'h00 || frame_tick !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_after an=%b seg=%h ft=%b required 00/00/0", an, seg, frame_tick);
        end
        rst = 1'b0;
        cyc = 0;
        repeat (16) begin
            int q;
            logic [1:0] ea;
            logic [6:0] es;
            logic eft;
            step();
            q   = (cyc - 1) % 16;
            ea  = ((q % 8) >= DC) ? ((q >= 8) ? 2'b10 : 2'b01) : 2'b00;
            es  = (ea == 2'b00) ? 7'h00 : 7'h3F;
            eft = (cyc == 16);
            checks++;
            if (an !== ea || seg !== es || frame_tick !== eft) begin
                errors++;
                $display("[TB] FAIL midrst_frame cyc=%0d an=%b seg=%h ft=%b required %b/%h/%b",
                         cyc, an, seg, frame_tick, ea, es, eft);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_tearing();
        test_blank();
        test_blink();
        test_mid_reset();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
